// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus request/response types and encodings used by the
// cache layer, the cbus arbiter and the AXI/cbus bridge.
package cbus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  // Burst length encoding: number of beats minus one.
  typedef logic [3:0] mlen_t;
  localparam mlen_t MLEN1  = 4'd0;
  localparam mlen_t MLEN2  = 4'd1;
  localparam mlen_t MLEN4  = 4'd3;
  localparam mlen_t MLEN8  = 4'd7;
  localparam mlen_t MLEN16 = 4'd15;

  // Beat size encoding: log2 of the number of bytes per beat.
  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  // AXI burst type encoding, passed straight through to the bridge.
  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
  localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
  localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    mlen_t             len;
    axi_burst_t        burst;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  // Number of beats a burst of the given length encoding carries.
  function automatic int mlen_beats(input mlen_t len);
    return int'({28'd0, len}) + 32'sd1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Round-robin priority picker: returns the first asserted request found
// when scanning upward from rr_ptr, wrapping modulo NUM_REQ.
// Purely combinational so it can be reused by other arbiters.
module cbus_arbiter_rr_select #(
  parameter  int NUM_REQ  = 2,
  localparam int IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [IDX_BITS-1:0] rr_ptr,
  output logic                found,
  output logic [IDX_BITS-1:0] idx
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  logic [IDX_BITS:0] cand;

  // Scan candidates in priority order; the first valid one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr} + (IDX_BITS+1)'(off);
      // Explicit wrap so non-power-of-two master counts work.
      if (cand >= (IDX_BITS+1)'(NUM_REQ)) begin
        cand = cand - (IDX_BITS+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!found && valid[cand[IDX_BITS-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_BITS-1:0];
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Shares the single memory-side cbus port between NUM_REQ cache masters.
// A grant covers a whole burst and is only released after the beat
// flagged last; a one-cycle bubble follows every burst so the releasing
// master sees last drop before the next arbitration. Round-robin order
// rotates to the master after the one that just finished.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  localparam int IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  cbus_req_t           ireqs  [NUM_REQ],
  output cbus_resp_t          iresps [NUM_REQ],
  output cbus_req_t           oreq,
  input  cbus_resp_t          oresp,
  output logic                busy,
  output logic [IDX_BITS-1:0] grant_idx
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_BITS-1:0] owner;
  logic [IDX_BITS-1:0] owner_next;
  logic [IDX_BITS-1:0] rr_ptr;
  logic [IDX_BITS-1:0] rr_ptr_next;
  logic [7:0]          beats;
  logic [7:0]          beats_next;

  logic [NUM_REQ-1:0]  req_valid;
  logic                sel_found;
  logic [IDX_BITS-1:0] sel_idx;
  logic [IDX_BITS:0]   owner_sum;
  logic [IDX_BITS-1:0] owner_inc;

  // Collect the per-master valid bits for the priority picker.
  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  cbus_arbiter_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .found  (sel_found),
    .idx    (sel_idx)
  );

  // Master after the current owner, wrapping explicitly at NUM_REQ.
  always_comb begin
    owner_sum = {1'b0, owner} + {{IDX_BITS{1'b0}}, 1'b1};
    if (owner_sum >= (IDX_BITS+1)'(NUM_REQ)) begin
      owner_inc = '0;
    end else begin
      owner_inc = owner_sum[IDX_BITS-1:0];
    end
  end

  // Arbitration state; reset drops any grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      beats  <= 8'd0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_ptr_next;
      beats  <= beats_next;
    end
  end

  // Next-state logic and port routing; the bus is only connected in GRANT.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    rr_ptr_next = rr_ptr;
    beats_next  = beats;
    oreq        = '0;
    busy        = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end

    case (state)
      IDLE: begin
        // Requests are only registered here, never forwarded, so a new
        // request reaches oreq one cycle after it is first seen.
        if (sel_found) begin
          owner_next = sel_idx;
          beats_next = 8'd0;
          state_next = GRANT;
        end else begin
          state_next = IDLE;
        end
      end

      GRANT: begin
        // The owner keeps the port even if it drops valid mid-burst.
        oreq          = ireqs[owner];
        iresps[owner] = oresp;
        busy          = 1'b1;
        grant_idx     = owner;
        if (oresp.ready) begin
          beats_next = beats + 8'd1;
          if (oresp.last) begin
            state_next  = RELEASE;
            rr_ptr_next = owner_inc;
          end else begin
            state_next  = GRANT;
          end
        end else begin
          beats_next = beats;
        end
      end

      RELEASE: begin
        // Bubble cycle: everything stays disconnected.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with a burst-level reference model that
// is compared against the DUT on every falling clock edge.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = 2;

  logic       clk;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [0:0] grant_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner = -1 when nobody holds the port; quiet counts the bubble cycles
  // after a burst during which no master may be picked.
  int         m_owner = -1;
  int         m_quiet = 0;
  int         m_ptr   = 0;
  logic [7:0] m_beats = 8'd0;

  function automatic int pick(input int ptr);
    for (int k = 0; k < N; k++) begin
      if (ireqs[(ptr + k) % N].valid === 1'b1) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= -1;
      m_quiet <= 0;
      m_ptr   <= 0;
      m_beats <= 8'd0;
    end else if (m_owner >= 0) begin
      if (oresp.ready === 1'b1) begin
        m_beats <= m_beats + 8'd1;
        if (oresp.last === 1'b1) begin
          m_owner <= -1;
          m_quiet <= 1;
          m_ptr   <= (m_owner + 1) % N;
        end
      end
    end else if (m_quiet > 0) begin
      m_quiet <= m_quiet - 1;
    end else if (pick(m_ptr) >= 0) begin
      m_owner <= pick(m_ptr);
      m_beats <= 8'd0;
    end
  end

  function automatic cbus_req_t exp_oreq();
    if (m_owner >= 0) return ireqs[m_owner];
    return cbus_req_t'(0);
  endfunction

  function automatic cbus_resp_t exp_iresp(input int i);
    if (m_owner == i) return oresp;
    return cbus_resp_t'(0);
  endfunction

  always @(negedge clk) begin
    check("oreq", oreq, exp_oreq());
    for (int i = 0; i < N; i++) check("iresps", iresps[i], exp_iresp(i));
    check("busy", busy, (m_owner >= 0));
    check("grant_idx", grant_idx, (m_owner >= 0) ? m_owner : 0);
    check("rr_ptr", dut.rr_ptr, m_ptr);
    check("beats", dut.beats, m_beats);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr, input mlen_t len,
                                       input logic [31:0] data, input logic [3:0] strb);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = addr;
    r.size     = MSIZE4;
    r.len      = len;
    r.burst    = AXI_BURST_INCR;
    r.strobe   = strb;
    r.data     = data;
    return r;
  endfunction

  task automatic wait_grant(input int exp_owner, output int gcyc);
    gcyc = -1;
    for (int k = 0; k < 20; k++) begin
      if (busy === 1'b1) begin
        gcyc = cyc;
        break;
      end
      tick();
    end
    check("grant_seen", (gcyc >= 0), 1'b1);
    check("grant_owner", grant_idx, exp_owner);
  endtask

  task automatic run_beats(input int n, output int lcyc);
    for (int b = 0; b < n; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == n - 1);
      oresp.data  = 32'h1000_0000 + 32'(b);
      tick();
    end
    oresp = '0;
    lcyc  = cyc;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) ireqs[i] = '0;
  endtask

  int g1, l1, g2, l2, req_cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_reqs();
    oresp = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_grant_idx", grant_idx, 1'b0);
    check("rst_oreq", oreq, 0);
    reset = 1'b0;
    tick();

    // Stray response while idle must not reach any master.
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 32'hcafe_f00d;
    #1;
    check("stray_iresp0", iresps[0], 0);
    check("stray_iresp1", iresps[1], 0);
    tick();
    oresp = '0;
    check("stray_beats", dut.beats, 8'd0);
    tick();

    // Single master 16-beat read.
    ireqs[1] = mk_req(1'b0, 32'h8000_0080, MLEN16, 32'h0, 4'h0);
    req_cyc  = cyc;
    #1;
    check("no_comb_path", oreq.valid, 1'b0);
    wait_grant(1, g1);
    check("grant_latency", g1 - req_cyc, 1);
    check("single_addr", oreq.addr, 32'h8000_0080);
    run_beats(mlen_beats(MLEN16), l1);
    ireqs[1] = '0;
    check("single_beats", dut.beats, 8'd16);
    check("rel_busy0", busy, 1'b0);
    tick();
    check("rel_busy1", busy, 1'b0);
    check("single_rr_ptr", dut.rr_ptr, 1'b0);

    // Tie after rr_ptr=0: master 0 first, master 1 two cycles after last.
    ireqs[0] = mk_req(1'b0, 32'h0000_1000, MLEN4, 32'h0, 4'h0);
    ireqs[1] = mk_req(1'b0, 32'h0000_2000, MLEN4, 32'h0, 4'h0);
    wait_grant(0, g1);
    run_beats(4, l1);
    ireqs[0] = '0;
    wait_grant(1, g2);
    check("tie_gap", g2 - l1, 2);
    run_beats(4, l2);
    ireqs[1] = '0;
    tick();
    tick();

    // Fairness: both masters keep requesting; grants alternate 0,1,0,1.
    ireqs[0] = mk_req(1'b0, 32'h0000_3000, MLEN2, 32'h0, 4'h0);
    ireqs[1] = mk_req(1'b1, 32'h0000_4000, MLEN2, 32'h1234_5678, 4'hf);
    l1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(k % 2, g1);
      if (k > 0) check("fair_gap", g1 - l1, 2);
      run_beats(2, l1);
    end
    clear_reqs();
    tick();
    tick();

    // Uncached single-beat write from master 1.
    ireqs[1] = mk_req(1'b1, 32'h1000_0040, MLEN1, 32'hdead_beef, 4'h0f);
    wait_grant(1, g1);
    check("sb_is_write", oreq.is_write, 1'b1);
    check("sb_data", oreq.data, 32'hdead_beef);
    check("sb_strobe", oreq.strobe, 4'h0f);
    check("sb_len", oreq.len, MLEN1);
    check("sb_addr", oreq.addr, 32'h1000_0040);
    run_beats(1, l1);
    ireqs[1] = '0;
    check("sb_beats", dut.beats, 8'd1);
    check("sb_busy", busy, 1'b0);
    tick();
    tick();

    // Writeback then fetch from master 0 with valid held continuously.
    ireqs[0] = mk_req(1'b1, 32'h8000_0100, MLEN16, 32'h5555_aaaa, 4'hf);
    wait_grant(0, g1);
    run_beats(16, l1);
    ireqs[0] = mk_req(1'b0, 32'h8000_0200, MLEN16, 32'h0, 4'h0);
    check("wb_rr_ptr", dut.rr_ptr, 1'b1);
    wait_grant(0, g2);
    check("wb_gap", g2 - l1, 2);
    check("fetch_is_write", oreq.is_write, 1'b0);
    check("fetch_addr", oreq.addr, 32'h8000_0200);
    run_beats(16, l2);
    ireqs[0] = '0;
    tick();
    tick();

    // Asynchronous reset after beat 5 of a 16-beat burst.
    ireqs[1] = mk_req(1'b0, 32'h8000_0300, MLEN16, 32'h0, 4'h0);
    wait_grant(1, g1);
    for (int b = 0; b < 5; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = 1'b0;
      oresp.data  = 32'h2000_0000 + 32'(b);
      tick();
    end
    check("mid_beats", dut.beats, 8'd5);
    check("mid_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_oreq_valid", oreq.valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_grant_idx", grant_idx, 1'b0);
    check("arst_iresp1", iresps[1], 0);
    clear_reqs();
    oresp = '0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    tick();
    tick();
    check("post_busy", busy, 1'b0);
    check("post_grant_idx", grant_idx, 1'b0);
    check("post_rr_ptr", dut.rr_ptr, 1'b0);
    check("post_beats", dut.beats, 8'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
